clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//  Mode/enable sequencer for the alarm-clock datapath. Sits between the manual buttons
//  and the ct_mod_N time/alarm counters: generates the count enables for seconds,
//  minutes, hours and the alarm-minute/hour registers; selects time vs alarm display;
//  runs the alarm ring/timeout FSM that drives Buzz.
// PARAMETERS
//  RING_SECS    60   ticks Buzz stays on before auto-stop (>=1)
//  SNOOZE_SECS  300  ticks of silence after snooze before re-ring (>=1; SNOOZE_EN only)
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst        in   1  asynchronous, active-low reset (0 = reset)
//  tick       in   1  1-cycle strobe, once per second (clk domain)
//  timeset    in   1  button level, async; hold = set time
//  alarmset   in   1  button level, async; hold = set alarm
//  minadv     in   1  button level, async; advance minutes while setting
//  hrsadv     in   1  button level, async; advance hours while setting
//  alarmon    in   1  switch level, async; arms alarm
//  snooze     in   1  button level, async; snooze while ringing
//  sec_last   in   1  seconds counter == 59
//  min_last   in   1  minutes counter == 59
//  alarm_match in  1  time hrs:min == alarm hrs:min (from comparator)
//  sen        out  1  seconds counter enable
//  tmen/then  out  1  time minute / hour counter enables
//  amen/ahen  out  1  alarm minute / hour register enables
//  show_alarm out  1  1 = display muxes select alarm regs for Min/Hrs
//  buzz       out  1  alarm sounding
// BEHAVIOUR
//  - All async button inputs pass a 2-flop synchronizer (_s); 2-cycle input latency.
//  - Mode FSM (registered): RUN, TSET, ASET. Reset -> RUN.
//    RUN->TSET if timeset_s; RUN->ASET if alarmset_s & !timeset_s (timeset wins).
//    TSET->RUN when !timeset_s; ASET->RUN when !alarmset_s; no direct TSET<->ASET
//    (always >=1 cycle in RUN between).
//  - Enables are combinational from mode state, _s inputs and tick; never high without tick.
//    RUN : sen=tick; tmen=tick&sec_last; then=tick&sec_last&min_last; amen=ahen=0.
//    TSET: sen=0 (seconds frozen); tmen=tick&minadv_s; then=tick&hrsadv_s; amen=ahen=0.
//    ASET: sen=tick; time carries as RUN; amen=tick&minadv_s; ahen=tick&hrsadv_s.
//    show_alarm = (mode==ASET), registered.
//  - Alarm FSM (registered): OFF, ARMED, RING, SNOOZE. Reset -> OFF, buzz=0.
//    Any state -> OFF when !alarmon_s (highest priority). OFF->ARMED when alarmon_s.
//    ARMED->RING on rising edge of alarm_match (match & !match_q) while mode==RUN;
//    match_q sampled every cycle, so holding time in TSET/ASET never triggers.
//    RING: buzz=1; ring counter loads RING_SECS on entry, decrements on tick;
//    at 0 -> ARMED (no re-trigger in same minute: match already high).
//  - Timer counter width = $clog2(max(RING_SECS,SNOOZE_SECS)+1); single shared counter.
//  - buzz is a registered output = (alarm state==RING).
//  - Async reset mid-operation: all state, synchronizers, counter, outputs -> 0 / RUN / OFF.
//  - tick coincident with state change: enables use the pre-edge (current) state.
// CONFIGURATION
//  SNOOZE_EN defined: RING->SNOOZE on rising edge of snooze_s; counter loads
//    SNOOZE_SECS, decrements on tick; at 0 -> RING (ring counter reloaded RING_SECS).
//    snooze in any other state ignored.
//  SNOOZE_EN undefined: snooze port present but ignored; SNOOZE state not built;
//    RING exits only on timeout or !alarmon_s.
// TESTING
//  1 RUN, sec_last=1,min_last=1, tick pulse -> sen,tmen,then all 1 for that cycle only.
//  2 timeset=1 + alarmset=1 together -> TSET after 2-3 clks; sen=0; minadv=1 + 3 ticks
//    -> exactly 3 tmen pulses, amen stays 0; release -> RUN, show_alarm=0.
//  3 alarmset=1, hrsadv=1, 5 ticks -> 5 ahen pulses, show_alarm=1, then=0 unless carry.
//  4 alarmon=1, alarm_match 0->1 in RUN -> buzz=1 within 3 clks; RING_SECS=4: after
//    4 ticks buzz=0, state ARMED; match held high -> no re-ring.
//  5 RING, alarmon->0 -> buzz=0 within 3 clks, state OFF; rst=0 mid-RING -> buzz=0 async.
//  6 SNOOZE_EN, SNOOZE_SECS=2: snooze press in RING -> buzz=0; 2 ticks -> buzz=1 again;
//    without SNOOZE_EN same stimulus -> buzz stays 1.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode/enable sequencer for the alarm clock: counter enables, display select, alarm ring FSM.
// Latency: buttons pass a 2-flop synchronizer; enables are combinational on tick; show_alarm/buzz are registered.
// Backpressure: none; every enable is a single-cycle strobe qualified by tick.
// Optional snooze support is built when SNOOZE_EN is defined.
module clock_mode_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic timeset,
  input  logic alarmset,
  input  logic minadv,
  input  logic hrsadv,
  input  logic alarmon,
  input  logic snooze,
  input  logic sec_last,
  input  logic min_last,
  input  logic alarm_match,
  output logic sen,
  output logic tmen,
  output logic then,
  output logic amen,
  output logic ahen,
  output logic show_alarm,
  output logic buzz
);

  // One shared countdown serves both ring and snooze, so size it for the longer one.
  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = $clog2(MAX_SECS + 1);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] RING_LD = CW'(RING_SECS);
`ifdef SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LD  = CW'(SNOOZE_SECS);
`endif

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TSET = 2'd1,
    ASET = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    AL_OFF    = 2'd0,
    AL_ARMED  = 2'd1,
    AL_RING   = 2'd2,
    AL_SNOOZE = 2'd3
  } alarm_t;

  // ---------------------------------------------------------------------------
  // Button synchronizers
  // ---------------------------------------------------------------------------
  logic [4:0] sync_meta;
  logic [4:0] sync_q;
  logic       timeset_s;
  logic       alarmset_s;
  logic       minadv_s;
  logic       hrsadv_s;
  logic       alarmon_s;

  // Two-flop synchronizer for the asynchronous button/switch levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {alarmon, hrsadv, minadv, alarmset, timeset};
      sync_q    <= sync_meta;
    end
  end

  assign timeset_s  = sync_q[0];
  assign alarmset_s = sync_q[1];
  assign minadv_s   = sync_q[2];
  assign hrsadv_s   = sync_q[3];
  assign alarmon_s  = sync_q[4];

`ifdef SNOOZE_EN
  logic snooze_meta;
  logic snooze_s;
  logic snooze_q;
  logic snooze_rise;

  // Snooze gets its own synchronizer plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snooze_meta <= 1'b0;
      snooze_s    <= 1'b0;
      snooze_q    <= 1'b0;
    end else begin
      snooze_meta <= snooze;
      snooze_s    <= snooze_meta;
      snooze_q    <= snooze_s;
    end
  end

  assign snooze_rise = snooze_s & ~snooze_q;
`else
  // Port kept so both builds share one pinout; the button has no effect here.
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // ---------------------------------------------------------------------------
  // Alarm match edge detect (sampled every cycle regardless of mode, so a
  // match that appears while setting time never fires on return to RUN)
  // ---------------------------------------------------------------------------
  logic match_q;
  logic match_rise;

  // Previous-cycle copy of the comparator output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= alarm_match;
    end
  end

  assign match_rise = alarm_match & ~match_q;

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_t mode;
  mode_t mode_nxt;

  // Mode state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode <= RUN;
    end else begin
      mode <= mode_nxt;
    end
  end

  // Mode next state: setting modes are only entered from and left to RUN;
  // time-set wins when both set buttons are held.
  always_comb begin
    mode_nxt = mode;
    case (mode)
      RUN: begin
        if (timeset_s) begin
          mode_nxt = TSET;
        end else if (alarmset_s) begin
          mode_nxt = ASET;
        end
      end
      TSET: begin
        if (!timeset_s) begin
          mode_nxt = RUN;
        end
      end
      ASET: begin
        if (!alarmset_s) begin
          mode_nxt = RUN;
        end
      end
      default: mode_nxt = RUN;
    endcase
  end

  // Counter enables from the current mode; every enable is gated by tick.
  always_comb begin
    sen  = 1'b0;
    tmen = 1'b0;
    then = 1'b0;
    amen = 1'b0;
    ahen = 1'b0;
    case (mode)
      RUN: begin
        sen  = tick;
        tmen = tick & sec_last;
        then = tick & sec_last & min_last;
      end
      TSET: begin
        // Seconds are frozen while the time is being set.
        tmen = tick & minadv_s;
        then = tick & hrsadv_s;
      end
      ASET: begin
        // Time keeps running while the alarm registers are adjusted.
        sen  = tick;
        tmen = tick & sec_last;
        then = tick & sec_last & min_last;
        amen = tick & minadv_s;
        ahen = tick & hrsadv_s;
      end
      default: begin
        sen = 1'b0;
      end
    endcase
  end

  // Display select register, tracking the mode state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      show_alarm <= 1'b0;
    end else begin
      show_alarm <= (mode_nxt == ASET);
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm FSM with shared ring/snooze countdown
  // ---------------------------------------------------------------------------
  alarm_t        al_state;
  alarm_t        al_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Alarm state and countdown registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      al_state <= AL_OFF;
      cnt      <= '0;
    end else begin
      al_state <= al_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Alarm next state; disarming overrides everything else.
  always_comb begin
    al_nxt  = al_state;
    cnt_nxt = cnt;
    if (!alarmon_s) begin
      al_nxt  = AL_OFF;
      cnt_nxt = '0;
    end else begin
      case (al_state)
        AL_OFF: begin
          al_nxt = AL_ARMED;
        end
        AL_ARMED: begin
          if (match_rise && (mode == RUN)) begin
            al_nxt  = AL_RING;
            cnt_nxt = RING_LD;
          end
        end
        AL_RING: begin
`ifdef SNOOZE_EN
          if (snooze_rise) begin
            al_nxt  = AL_SNOOZE;
            cnt_nxt = SNZ_LD;
          end else if (tick) begin
            if (cnt <= ONE) begin
              // Back to ARMED; match is still high so no re-ring this minute.
              al_nxt  = AL_ARMED;
              cnt_nxt = '0;
            end else begin
              cnt_nxt = cnt - ONE;
            end
          end
`else
          if (tick) begin
            if (cnt <= ONE) begin
              // Back to ARMED; match is still high so no re-ring this minute.
              al_nxt  = AL_ARMED;
              cnt_nxt = '0;
            end else begin
              cnt_nxt = cnt - ONE;
            end
          end
`endif
        end
`ifdef SNOOZE_EN
        AL_SNOOZE: begin
          if (tick) begin
            if (cnt <= ONE) begin
              al_nxt  = AL_RING;
              cnt_nxt = RING_LD;
            end else begin
              cnt_nxt = cnt - ONE;
            end
          end
        end
`endif
        default: begin
          al_nxt  = AL_OFF;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Buzzer register, high exactly while the alarm FSM is in RING.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buzz <= 1'b0;
    end else begin
      buzz <= (al_nxt == AL_RING);
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomized bench for clock_mode_ctrl against a behavioural reference model.
// Latency: model tracks the 2-cycle button delay; outputs are compared every cycle.
// Backpressure: none; stimulus is free-running.
module tb_clock_mode_ctrl;

  localparam int RING = 4;
  localparam int SNZ  = 2;
`ifdef SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  localparam int M_RUN  = 0;
  localparam int M_TSET = 1;
  localparam int M_ASET = 2;
  localparam int A_OFF   = 0;
  localparam int A_ARMED = 1;
  localparam int A_RING  = 2;
  localparam int A_SNZ   = 3;

  logic clk = 1'b0;
  logic rst;
  logic tick, timeset, alarmset, minadv, hrsadv, alarmon, snooze;
  logic sec_last, min_last, alarm_match;
  logic sen, tmen, then, amen, ahen, show_alarm, buzz;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: raw button history (h1 = latest edge), match history, modes.
  logic [5:0] h1, h2, h3;
  logic       mq;
  int         m_mode, m_al, rem;

  always #5 clk = ~clk;

  clock_mode_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
    .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .alarmon(alarmon), .snooze(snooze),
    .sec_last(sec_last), .min_last(min_last), .alarm_match(alarm_match),
    .sen(sen), .tmen(tmen), .then(then), .amen(amen), .ahen(ahen),
    .show_alarm(show_alarm), .buzz(buzz)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {1'b0, sen, tmen, then, amen, ahen, show_alarm, buzz};
  endfunction

  // Expected outputs for the current cycle from the model state and live inputs.
  function automatic logic [7:0] model_outs();
    logic ma, ha, carry_m, carry_h;
    logic e_sen, e_tmen, e_then, e_amen, e_ahen;
    ma = h2[2];
    ha = h2[3];
    carry_m = tick & sec_last;
    carry_h = tick & sec_last & min_last;
    e_sen = 1'b0; e_tmen = 1'b0; e_then = 1'b0; e_amen = 1'b0; e_ahen = 1'b0;
    if (m_mode == M_RUN) begin
      e_sen = tick; e_tmen = carry_m; e_then = carry_h;
    end else if (m_mode == M_TSET) begin
      e_tmen = tick & ma; e_then = tick & ha;
    end else begin
      e_sen = tick; e_tmen = carry_m; e_then = carry_h;
      e_amen = tick & ma; e_ahen = tick & ha;
    end
    return {1'b0, e_sen, e_tmen, e_then, e_amen, e_ahen,
            (m_mode == M_ASET), (m_al == A_RING)};
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0; mq = 1'b0;
    m_mode = M_RUN; m_al = A_OFF; rem = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic ts, as_b, on_b, snz_rise;
    int   nal, nrem, nmode;
    ts = h2[0]; as_b = h2[1]; on_b = h2[4];
    snz_rise = h2[5] & ~h3[5];
    nal = m_al; nrem = rem; nmode = m_mode;
    if (!on_b) begin
      nal = A_OFF;
    end else if (m_al == A_OFF) begin
      nal = A_ARMED;
    end else if (m_al == A_ARMED) begin
      if (alarm_match && !mq && m_mode == M_RUN) begin
        nal = A_RING; nrem = RING;
      end
    end else if (m_al == A_RING) begin
      if (SNOOZE_ON && snz_rise) begin
        nal = A_SNZ; nrem = SNZ;
      end else if (tick) begin
        nrem = rem - 1;
        if (nrem == 0) nal = A_ARMED;
      end
    end else begin
      if (tick) begin
        nrem = rem - 1;
        if (nrem == 0) begin
          nal = A_RING; nrem = RING;
        end
      end
    end
    if (m_mode == M_RUN) begin
      if (ts) nmode = M_TSET;
      else if (as_b) nmode = M_ASET;
    end else if (m_mode == M_TSET) begin
      if (!ts) nmode = M_RUN;
    end else begin
      if (!as_b) nmode = M_RUN;
    end
    m_al = nal; rem = nrem; m_mode = nmode;
    mq = alarm_match;
    h3 = h2; h2 = h1;
    h1 = {snooze, alarmon, hrsadv, minadv, alarmset, timeset};
  endtask

  function automatic logic flip(input logic v, input int odds);
    return ($urandom_range(0, odds - 1) == 0) ? ~v : v;
  endfunction

  // Phase 0: everything random. Phase 1: alarm-focused, set buttons released.
  task automatic drive(input int phase);
    sec_last = 1'($urandom_range(0, 1));
    min_last = 1'($urandom_range(0, 1));
    if (phase == 0) begin
      tick        = ($urandom_range(0, 3) == 0);
      timeset     = flip(timeset, 12);
      alarmset    = flip(alarmset, 12);
      minadv      = flip(minadv, 6);
      hrsadv      = flip(hrsadv, 6);
      alarmon     = flip(alarmon, 20);
      snooze      = flip(snooze, 6);
      alarm_match = flip(alarm_match, 10);
    end else begin
      tick        = ($urandom_range(0, 2) == 0);
      timeset     = 1'b0;
      alarmset    = 1'b0;
      minadv      = flip(minadv, 6);
      hrsadv      = flip(hrsadv, 6);
      alarmon     = flip(alarmon, 150);
      snooze      = flip(snooze, 6);
      alarm_match = flip(alarm_match, 8);
    end
  endtask

  task automatic run_cycle(input int phase);
    @(negedge clk);
    drive(phase);
    #1;
    check($sformatf("outs cyc%0d", cyc), dut_outs(), model_outs());
    model_step();
    cyc++;
  endtask

  task automatic clear_inputs();
    tick = 0; timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0;
    alarmon = 0; snooze = 0; sec_last = 0; min_last = 0; alarm_match = 0;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset outs", dut_outs(), 8'h00);
    rst = 1'b1;
    model_step();

    for (int i = 0; i < 3000; i++) run_cycle(0);

    alarmon = 1'b1;
    for (int i = 0; i < 3000; i++) run_cycle(1);

    // Drive until the model is ringing, then pull reset asynchronously.
    alarmon = 1'b1;
    guard = 0;
    while (m_al != A_RING && guard < 3000) begin
      run_cycle(1);
      guard++;
    end
    if (m_al != A_RING) begin
      check("reach ring", 8'h00, 8'h01);
    end else begin
      @(posedge clk);
      #2;
      check("buzz before reset", {7'd0, buzz}, 8'h01);
      tick = 1'b0;
      rst  = 1'b0;
      #1;
      check("async reset outs", dut_outs(), 8'h00);
      clear_inputs();
      model_reset();
      @(negedge clk);
      check("reset held outs", dut_outs(), 8'h00);
      rst = 1'b1;
      model_step();
    end

    for (int i = 0; i < 1000; i++) run_cycle(0);
    alarmon = 1'b1;
    for (int i = 0; i < 1000; i++) run_cycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
